program_loader: RTL and testbench
=================================

# program_loader

Boot-time instruction loader for the pipelined MIPS core. It is the writer side of the instruction memory: it receives a length-prefixed, checksummed byte stream over a valid/ready byte interface and packs it into 32-bit words. It writes those words sequentially into instruction memory and holds the core in reset until a load completes with a correct checksum.

## Interface
- ADDR_WIDTH, 8, word-address width of instruction memory; capacity 2^ADDR_WIDTH words
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; returns block to IDLE
- start  in  1  begin a new load; sampled on rising edge
- byte_valid  in  1  source has a byte on byte_data
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  instruction memory write enable, one cycle per word
- mem_addr  out  ADDR_WIDTH  word address of the write
- mem_wdata  out  32  word being written
- core_reset  out  1  holds the pipeline in reset
- busy  out  1  load in progress
- done  out  1  last load finished with a good checksum
- error  out  1  last load failed (bad length or checksum)
- words_loaded  out  ADDR_WIDTH+1  words written in current or last load

## Operation
- Stream format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4N data bytes (each word MSB first), then one CSUM byte.
- CSUM must equal the XOR of all preceding bytes in the stream, length bytes included.
- A byte is accepted on a rising edge with byte_valid && byte_ready. No byte is accepted in any other cycle.
- States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, CSUM, DONE, ERROR.
- IDLE/DONE/ERROR + start → LEN_HI. On this transition the block clears words_loaded, the byte counter, the XOR accumulator, done and error.
- LEN_HI → LEN_LO on accept.
- LEN_LO → on accept:
  - N > 2^ADDR_WIDTH → ERROR
  - N == 0 → CSUM
  - otherwise → DATA
- DATA: shifts each accepted byte into the word register (first byte ends in bits 31:24). After the 4th byte → WRITE.
- WRITE, exactly one cycle:
  - mem_we=1, mem_addr = words_loaded[ADDR_WIDTH-1:0], mem_wdata = assembled word.
  - words_loaded increments at the end of the cycle.
  - Next state: DATA if words_loaded+1 < N, else CSUM.
- CSUM → on accept: byte == accumulator → DONE, else ERROR.
- byte_ready = 1 in LEN_HI, LEN_LO, DATA, CSUM; 0 in IDLE, WRITE, DONE, ERROR.
- busy = 1 in LEN_HI through CSUM.
- done = (state==DONE); error = (state==ERROR).
- core_reset = 0 only in DONE; 1 in every other state.
- start while busy is ignored.
- Words already written are never rolled back on error.

## Timing
- Reset values: state IDLE, byte_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, core_reset 1, busy 0, done 0, error 0, words_loaded 0, accumulator 0.
- All outputs are registered or decoded from the registered state; there is no combinational path from byte_valid/byte_data/start to any output.
- Maximum throughput is 5 cycles per word: 4 accept cycles plus 1 WRITE cycle.
- mem_addr and mem_wdata hold their last written values outside WRITE.
- core_reset falls on the first cycle in DONE. It rises again on the cycle after a start is accepted.
- Gaps in byte_valid stall the FSM with no state loss.
- Reset asserted mid-load goes to IDLE immediately and asynchronously:
  - any partial word is discarded and no further write occurs;
  - mem_we drops immediately.
- When N == 2^ADDR_WIDTH, the final write lands at address 2^ADDR_WIDTH−1. There is no wrap-around.

## Test plan
- Two-word load: start, then bytes 00 02 DE AD BE EF 00 00 00 01 21 → writes addr0=DEADBEEF and addr1=00000001, one mem_we cycle each. Then done=1, core_reset=0, words_loaded=2.
- Same stream with CSUM 20 → both writes still occur, then error=1, done=0, core_reset stays 1.
- Empty load: bytes 00 00 00 → done=1, no mem_we ever asserted, words_loaded=0.
- Oversize (ADDR_WIDTH=8): bytes 01 01 → ERROR on the cycle after the 2nd accept, byte_ready=0, no writes.
- byte_valid toggling every other cycle during the two-word load → same writes and result, 5+ cycles per word. A start pulsed mid-load is ignored.
- Reset after 2 data bytes → IDLE, no write, core_reset=1. A subsequent start followed by the full two-word stream completes with done=1.

Source files
------------

// File: rtl/program_loader.sv
// ----------------------------------------------------------------------------
// program_loader
//
// Boot-time instruction loader. It consumes a length-prefixed, checksummed
// byte stream, packs the data bytes into 32-bit words (MSB first), and writes
// them sequentially into instruction memory. The core is held in reset until
// a load completes with a matching checksum.
//
// Stream: LEN_HI, LEN_LO (word count N, big-endian), 4*N data bytes, CSUM.
// CSUM is the XOR of every preceding byte, length bytes included.
//
// Handshake: a byte is transferred on a rising clock edge when
// byte_valid && byte_ready. byte_ready is decoded from the registered state
// only, so it never depends on byte_valid in the same cycle.
//
// Ports:
//   clock, reset        system clock; asynchronous active-high reset
//   start               begin a new load (ignored while busy)
//   byte_valid/data     input byte stream
//   byte_ready          loader accepts a byte this cycle
//   mem_we/addr/wdata   instruction memory write port, one cycle per word
//   core_reset          low only after a good load
//   busy, done, error   load status
//   words_loaded        words written in current or last load
//   fsm_state           current FSM state, for observation
// ----------------------------------------------------------------------------
module program_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  core_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded,
  output logic [2:0]            fsm_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_CSUM   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERROR  = 3'd7;

  // Memory capacity in words, widened so N == 2^ADDR_WIDTH is representable.
  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

  logic [2:0]  state;
  logic [15:0] len;        // word count N
  logic [1:0]  byte_cnt;   // byte position within current word
  logic [23:0] word_part;  // first three bytes of the word being assembled
  logic [7:0]  acc;        // running XOR of accepted bytes

  logic        accept;
  logic [15:0] len_full;
  logic [16:0] words_next;
  logic        more_words;

  assign accept     = byte_valid && byte_ready;
  // Full length as it will be once the LEN_LO byte is taken.
  assign len_full   = {len[15:8], byte_data};
  assign words_next = 17'(words_loaded) + 17'd1;
  assign more_words = words_next < {1'b0, len};

  // All status outputs are pure decodes of the registered state.
  always_comb begin
    byte_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                 (state == S_DATA)   || (state == S_CSUM);
    busy       = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                 (state == S_DATA)   || (state == S_WRITE)  ||
                 (state == S_CSUM);
    mem_we     = (state == S_WRITE);
    done       = (state == S_DONE);
    error      = (state == S_ERROR);
    core_reset = (state != S_DONE);
    fsm_state  = state;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      len          <= '0;
      byte_cnt     <= '0;
      word_part    <= '0;
      acc          <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      words_loaded <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state        <= S_LEN_HI;
            words_loaded <= '0;
            byte_cnt     <= '0;
            acc          <= '0;
          end
        end

        S_LEN_HI: begin
          if (accept) begin
            len[15:8] <= byte_data;
            acc       <= acc ^ byte_data;
            state     <= S_LEN_LO;
          end
        end

        S_LEN_LO: begin
          if (accept) begin
            len[7:0] <= byte_data;
            acc      <= acc ^ byte_data;
            if ({1'b0, len_full} > CAPACITY) begin
              state <= S_ERROR;
            end else if (len_full == 16'd0) begin
              state <= S_CSUM;
            end else begin
              state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (accept) begin
            acc       <= acc ^ byte_data;
            word_part <= {word_part[15:0], byte_data};
            byte_cnt  <= byte_cnt + 2'd1;
            // Fourth byte: latch the write port now so it stays stable
            // through WRITE and holds afterwards.
            if (byte_cnt == 2'd3) begin
              mem_wdata <= {word_part, byte_data};
              mem_addr  <= words_loaded[ADDR_WIDTH-1:0];
              state     <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          words_loaded <= words_loaded + (ADDR_WIDTH+1)'(1);
          state        <= more_words ? S_DATA : S_CSUM;
        end

        S_CSUM: begin
          if (accept) begin
            state <= (byte_data == acc) ? S_DONE : S_ERROR;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// ----------------------------------------------------------------------------
// tb_program_loader
//
// Table-driven bench for program_loader: each record is a complete byte
// stream plus the expected end status and memory writes. Hand-written
// sequences cover reset in the middle of a load and during a write.
// ----------------------------------------------------------------------------
module tb_program_loader;

  localparam int AW = 8;
  localparam int W  = AW + 32;

  // Clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic          start;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          core_reset;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;
  logic [2:0]    fsm_state;

  program_loader #(.ADDR_WIDTH(AW)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .core_reset   (core_reset),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded),
    .fsm_state    (fsm_state)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected {addr, data} per write, in order
  logic [W-1:0] exp_q[$];
  int cycle       = 0;
  int write_count = 0;
  int prev_cycle  = 0;
  int last_spacing = 0;
  bit have_prev   = 0;

  always @(posedge clock) cycle++;

  always @(negedge clock) begin
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                 mem_addr, mem_wdata);
      end else begin
        check("write", 64'({mem_addr, mem_wdata}), 64'(exp_q.pop_front()));
      end
      write_count++;
      if (have_prev) last_spacing = cycle - prev_cycle;
      prev_cycle = cycle;
      have_prev  = 1;
    end
  end

  // Driver tasks: entered and left at a falling edge.
  task automatic send_byte(input logic [7:0] b);
    int budget = 50;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    if (budget == 0) begin
      checks++;
      failures++;
      $display("FAIL byte_timeout: got byte_ready 0 expected 1 for byte %0h", b);
      byte_valid = 1'b0;
    end else begin
      @(negedge clock);
      byte_valid = 1'b0;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  typedef struct {
    string       name;
    int          n;
    logic [7:0]  b[0:11];
    int          gap;
    int          start_at;
    logic        exp_done;
    logic        exp_error;
    int          exp_words;
    int          exp_writes;
    logic [31:0] w[0:1];
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input vec_t v);
    write_count = 0;
    have_prev   = 0;
    last_spacing = 0;
    for (int k = 0; k < v.exp_writes; k++)
      exp_q.push_back({AW'(k), v.w[k]});
    pulse_start();
    check({v.name, "_busy_after_start"}, 64'(busy), 64'(1));
    check({v.name, "_core_reset_after_start"}, 64'(core_reset), 64'(1));
    check({v.name, "_words_cleared"}, 64'(words_loaded), 64'(0));
    check({v.name, "_status_cleared"}, 64'({done, error}), 64'(0));
    for (int i = 0; i < v.n; i++) begin
      if (i == v.start_at) start = 1'b1;
      send_byte(v.b[i]);
      start = 1'b0;
      repeat (v.gap) @(negedge clock);
    end
    check({v.name, "_done"}, 64'(done), 64'(v.exp_done));
    check({v.name, "_error"}, 64'(error), 64'(v.exp_error));
    check({v.name, "_core_reset"}, 64'(core_reset), 64'(!v.exp_done));
    check({v.name, "_busy"}, 64'(busy), 64'(0));
    check({v.name, "_byte_ready"}, 64'(byte_ready), 64'(0));
    check({v.name, "_words_loaded"}, 64'(words_loaded), 64'(v.exp_words));
    check({v.name, "_write_count"}, 64'(write_count), 64'(v.exp_writes));
    check({v.name, "_queue_drained"}, 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    if (v.exp_writes == 2) begin
      if (v.gap == 0) check({v.name, "_spacing"}, 64'(last_spacing), 64'(5));
      else check({v.name, "_spacing_min"}, 64'(last_spacing >= 5), 64'(1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0].name = "two_word";
    vecs[0].n = 11;
    vecs[0].b = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                  8'h00, 8'h00, 8'h00, 8'h01, 8'h21, 8'h00};
    vecs[0].gap = 0; vecs[0].start_at = -1;
    vecs[0].exp_done = 1; vecs[0].exp_error = 0;
    vecs[0].exp_words = 2; vecs[0].exp_writes = 2;
    vecs[0].w = '{32'hDEADBEEF, 32'h00000001};

    vecs[1] = vecs[0];
    vecs[1].name = "bad_csum";
    vecs[1].b[10] = 8'h20;
    vecs[1].exp_done = 0; vecs[1].exp_error = 1;

    vecs[2].name = "empty";
    vecs[2].n = 3;
    vecs[2].b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[2].gap = 0; vecs[2].start_at = -1;
    vecs[2].exp_done = 1; vecs[2].exp_error = 0;
    vecs[2].exp_words = 0; vecs[2].exp_writes = 0;
    vecs[2].w = '{32'h0, 32'h0};

    vecs[3] = vecs[2];
    vecs[3].name = "oversize";
    vecs[3].n = 2;
    vecs[3].b[0] = 8'h01; vecs[3].b[1] = 8'h01;
    vecs[3].exp_done = 0; vecs[3].exp_error = 1;

    vecs[4] = vecs[0];
    vecs[4].name = "gapped";
    vecs[4].gap = 1; vecs[4].start_at = 5;

    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(negedge clock);
    check("rst_byte_ready", 64'(byte_ready), 64'(0));
    check("rst_mem_we", 64'(mem_we), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    check("rst_core_reset", 64'(core_reset), 64'(1));
    check("rst_status", 64'({busy, done, error}), 64'(0));
    check("rst_words_loaded", 64'(words_loaded), 64'(0));
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("idle_byte_ready", 64'(byte_ready), 64'(0));
    check("idle_core_reset", 64'(core_reset), 64'(1));

    for (int t = 0; t < 5; t++) begin
      run_vec(vecs[t]);
      repeat (2) @(negedge clock);
    end

    // Reset after two data bytes: partial word discarded, no write.
    write_count = 0;
    pulse_start();
    send_byte(8'h00); send_byte(8'h02); send_byte(8'hDE); send_byte(8'hAD);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_core_reset", 64'(core_reset), 64'(1));
    check("mid_rst_byte_ready", 64'(byte_ready), 64'(0));
    check("mid_rst_words", 64'(words_loaded), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    repeat (8) @(negedge clock);
    check("mid_rst_no_write", 64'(write_count), 64'(0));
    run_vec(vecs[0]);
    repeat (2) @(negedge clock);

    // Reset while the write strobe is up: it must drop at once.
    exp_q.push_back({AW'(0), 32'hDEADBEEF});
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    check("write_rst_we_before", 64'(mem_we), 64'(1));
    #2 reset = 1'b1;
    #1;
    check("write_rst_we_after", 64'(mem_we), 64'(0));
    check("write_rst_addr", 64'(mem_addr), 64'(0));
    check("write_rst_words", 64'(words_loaded), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("write_rst_queue", 64'(exp_q.size()), 64'(0));
    exp_q.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
